// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM request arbiter: command pin encodings,
// the queued request layout and the arbiter state encoding.
package sdram_pkg;

    localparam logic [3:0] CMD_WRITE   = 4'b0100;
    localparam logic [3:0] CMD_READ    = 4'b0101;
    localparam logic [3:0] CMD_REFRESH = 4'b0001;

    localparam int REQ_ADDR_W = 22;
    localparam int REQ_DATA_W = 16;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] data;
    } sdram_req_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_ISSUE = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_DONE  = 2'd3
    } arb_state_e;

    function automatic logic is_write_cmd(input logic [3:0] cmd);
        return (cmd == CMD_WRITE);
    endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous show-ahead request queue; full/empty flags are registered and a
// push is still taken when full provided the head is popped in the same cycle.
module sdram_req_fifo
    import sdram_pkg::*;
#(
    parameter int Width = 39,
    parameter int Depth = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [Width-1:0] i_din,
    input  logic             i_pop,
    output logic [Width-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int IdxW = $clog2(Depth);
    localparam int PtrW = IdxW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer, storage and flag next-state.
    always_comb begin
        mem_d     = mem_q;
        do_pop_s  = i_pop && !empty_q;
        do_push_s = i_push && (!full_q || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q[IdxW-1:0]] = i_din;
            wr_ptr_d = wr_ptr_q + PtrW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // Pointers carry one extra wrap bit so full and empty are distinguishable.
        full_d  = (wr_ptr_d[PtrW-1] != rd_ptr_d[PtrW-1]) &&
                  (wr_ptr_d[IdxW-1:0] == rd_ptr_d[IdxW-1:0]);
        empty_d = (wr_ptr_d == rd_ptr_d);
    end

    // Queue state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= {PtrW{1'b0}};
            rd_ptr_q <= {PtrW{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= {Width{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            mem_q    <= mem_d;
        end
    end

    assign o_head  = mem_q[rd_ptr_q[IdxW-1:0]];
    assign o_full  = full_q;
    assign o_empty = empty_q;

endmodule

// File: rtl/sdram_req_arbiter.sv
// Queues user read/write requests and hands them one at a time to the SDRAM
// controller. Define SDRAM_REQ_ARB_TIMEOUT_EN to add the o_err watchdog.
module sdram_req_arbiter
    import sdram_pkg::*;
#(
    parameter int AddrWidth     = 22,
    parameter int DataWidth     = 16,
    parameter int FifoDepth     = 4,
    parameter int TimeoutCycles = 64
) (
    input  logic                 i_dram_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_we,
    input  logic [AddrWidth-1:0] i_req_addr,
    input  logic [DataWidth-1:0] i_req_data,
    output logic                 o_rsp_valid,
    output logic [DataWidth-1:0] o_rsp_data,
    output logic                 o_idle,
    output logic                 o_wr_req,
    output logic [AddrWidth-1:0] o_wr_addr,
    output logic [DataWidth-1:0] o_wr_data,
    output logic                 o_rd_req,
    output logic [AddrWidth-1:0] o_rd_addr,
    input  logic [DataWidth-1:0] i_rd_data,
    input  logic                 i_rd_rdy,
`ifdef SDRAM_REQ_ARB_TIMEOUT_EN
    output logic                 o_err,
`endif
    input  logic                 i_cmd_cs_n,
    input  logic                 i_cmd_ras_n,
    input  logic                 i_cmd_cas_n,
    input  logic                 i_cmd_we_n
);

    localparam int EntryW = 1 + AddrWidth + DataWidth;

    arb_state_e           state_q, state_d;
    logic                 wr_req_q, wr_req_d;
    logic                 rd_req_q, rd_req_d;
    logic [AddrWidth-1:0] wr_addr_q, wr_addr_d;
    logic [DataWidth-1:0] wr_data_q, wr_data_d;
    logic [AddrWidth-1:0] rd_addr_q, rd_addr_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0] rsp_data_q, rsp_data_d;

    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic [EntryW-1:0]    fifo_head_s;
    logic                 head_we_s;
    logic [AddrWidth-1:0] head_addr_s;
    logic [DataWidth-1:0] head_data_s;
    logic                 write_hit_s;

`ifdef SDRAM_REQ_ARB_TIMEOUT_EN
    localparam int            CntW     = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles - 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    assign push_s      = i_req_valid && !fifo_full_s;
    assign write_hit_s = is_write_cmd({i_cmd_cs_n, i_cmd_ras_n, i_cmd_cas_n, i_cmd_we_n});
    assign {head_we_s, head_addr_s, head_data_s} = fifo_head_s;

    sdram_req_fifo #(
        .Width (EntryW),
        .Depth (FifoDepth)
    ) u_fifo (
        .i_clk   (i_dram_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push_s),
        .i_din   ({i_req_we, i_req_addr, i_req_data}),
        .i_pop   (pop_s),
        .o_head  (fifo_head_s),
        .o_full  (fifo_full_s),
        .o_empty (fifo_empty_s)
    );

    // Issue FSM next-state and registered output values.
    always_comb begin
        state_d     = state_q;
        wr_req_d    = wr_req_q;
        rd_req_d    = rd_req_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        pop_s       = 1'b0;
`ifdef SDRAM_REQ_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                wr_req_d = 1'b0;
                rd_req_d = 1'b0;
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
`ifdef SDRAM_REQ_ARB_TIMEOUT_EN
                    cnt_d = {CntW{1'b0}};
`endif
                    if (head_we_s) begin
                        state_d   = ST_WR_ISSUE;
                        wr_req_d  = 1'b1;
                        wr_addr_d = head_addr_s;
                        wr_data_d = head_data_s;
                    end else begin
                        state_d   = ST_RD_ISSUE;
                        rd_req_d  = 1'b1;
                        rd_addr_d = head_addr_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_ISSUE: begin
                // Refresh or other commands only lengthen the hold; only WRITE completes it.
                if (write_hit_s) begin
                    wr_req_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
`ifdef SDRAM_REQ_ARB_TIMEOUT_EN
                    if (cnt_q == CntLimit) begin
                        err_d    = 1'b1;
                        wr_req_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d    = cnt_q + CntW'(1'b1);
                        wr_req_d = 1'b1;
                    end
`else
                    wr_req_d = 1'b1;
`endif
                end
            end
            ST_RD_ISSUE: begin
                if (i_rd_rdy) begin
                    rd_req_d    = 1'b0;
                    rsp_data_d  = i_rd_data;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RD_DONE;
                end else begin
`ifdef SDRAM_REQ_ARB_TIMEOUT_EN
                    if (cnt_q == CntLimit) begin
                        err_d    = 1'b1;
                        rd_req_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d    = cnt_q + CntW'(1'b1);
                        rd_req_d = 1'b1;
                    end
`else
                    rd_req_d = 1'b1;
`endif
                end
            end
            ST_RD_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                wr_req_d = 1'b0;
                rd_req_d = 1'b0;
            end
        endcase
    end

    // FSM and output registers with synchronous reset.
    always_ff @(posedge i_dram_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_addr_q   <= {AddrWidth{1'b0}};
            wr_data_q   <= {DataWidth{1'b0}};
            rd_addr_q   <= {AddrWidth{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {DataWidth{1'b0}};
        end else begin
            state_q     <= state_d;
            wr_req_q    <= wr_req_d;
            rd_req_q    <= rd_req_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_addr_q   <= rd_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

`ifdef SDRAM_REQ_ARB_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge i_dram_clk) begin
        if (!i_rst_n) begin
            cnt_q <= {CntW{1'b0}};
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`endif

    assign o_req_ready = !fifo_full_s;
    assign o_idle      = (state_q == ST_IDLE) && fifo_empty_s;
    assign o_wr_req    = wr_req_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_rd_req    = rd_req_q;
    assign o_rd_addr   = rd_addr_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Scoreboard bench for sdram_req_arbiter: expected issues are queued at push
// time and checked when the arbiter raises o_wr_req/o_rd_req.
module tb_sdram_req_arbiter;

    localparam logic [3:0] NOP     = 4'b0111;
    localparam logic [3:0] WRITE   = 4'b0100;
    localparam logic [3:0] REFRESH = 4'b0001;

    typedef struct {
        bit          we;
        logic [21:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [21:0] req_addr = 22'h0;
    logic [15:0] req_data = 16'h0;
    logic [15:0] rd_data = 16'h0;
    logic        rd_rdy = 1'b0;
    logic [3:0]  cmd = NOP;
    logic        req_ready, rsp_valid, idle, wr_req, rd_req;
    logic [15:0] rsp_data, wr_data;
    logic [21:0] wr_addr, rd_addr;
`ifdef SDRAM_REQ_ARB_TIMEOUT_EN
    logic        err;
`endif

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    sdram_req_arbiter #(
        .AddrWidth(22), .DataWidth(16), .FifoDepth(4), .TimeoutCycles(16)
    ) dut (
        .i_dram_clk (clk),       .i_rst_n    (rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_we   (req_we),    .i_req_addr (req_addr),
        .i_req_data (req_data),  .o_rsp_valid(rsp_valid),
        .o_rsp_data (rsp_data),  .o_idle     (idle),
        .o_wr_req   (wr_req),    .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),   .o_rd_req   (rd_req),
        .o_rd_addr  (rd_addr),   .i_rd_data  (rd_data),
        .i_rd_rdy   (rd_rdy),
`ifdef SDRAM_REQ_ARB_TIMEOUT_EN
        .o_err      (err),
`endif
        .i_cmd_cs_n (cmd[3]),    .i_cmd_ras_n(cmd[2]),
        .i_cmd_cas_n(cmd[1]),    .i_cmd_we_n (cmd[0])
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pushes one request (bounded wait for ready) and records the expected issue.
    task automatic push(input bit we, input logic [21:0] addr, input logic [15:0] data);
        int n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        if (!req_ready) begin
            n_cmp++; n_err++;
            $display("FAIL push_ready: ready=%b after %0d cycles, required 1", req_ready, n);
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_data = data;
        exp_q.push_back('{we, addr, data});
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_req(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (wr_req || rd_req) begin seen = 1'b1; return; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b want 1", idle); end
        n_cmp++; if ({wr_req, rd_req, rsp_valid} !== 3'b000) begin n_err++; $display("FAIL rst_strobes: got %b want 000", {wr_req, rd_req, rsp_valid}); end
        n_cmp++; if ({wr_addr, wr_data, rd_addr, rsp_data} !== 76'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", {wr_addr, wr_data, rd_addr, rsp_data}); end
    endtask

    task automatic test_write();
        exp_t e;
        push(1'b1, 22'h12345, 16'hA5A5);
        n_cmp++; if (wr_req !== 1'b0) begin n_err++; $display("FAIL wr_early: got %b want 0", wr_req); end
        tick();
        n_cmp++; if (wr_req !== 1'b1) begin n_err++; $display("FAIL wr_rise: got %b want 1", wr_req); end
        e = exp_q.pop_front();
        n_cmp++; if ({wr_addr, wr_data} !== {e.addr, e.data}) begin n_err++; $display("FAIL wr_fields: got %h/%h want %h/%h", wr_addr, wr_data, e.addr, e.data); end
        repeat (3) tick();
        n_cmp++; if ({wr_req, rd_req, wr_addr, wr_data} !== {2'b10, e.addr, e.data}) begin n_err++; $display("FAIL wr_hold: got %b%b %h/%h", wr_req, rd_req, wr_addr, wr_data); end
        cmd = WRITE; tick(); cmd = NOP;
        n_cmp++; if ({wr_req, idle} !== 2'b01) begin n_err++; $display("FAIL wr_done: wr_req/idle got %b want 01", {wr_req, idle}); end
    endtask

    task automatic test_refresh_hold();
        exp_t e;
        bit   seen;
        push(1'b1, 22'h0ABCD, 16'h1357);
        wait_req(10, seen);
        e = exp_q.pop_front();
        n_cmp++; if (!seen || wr_req !== 1'b1) begin n_err++; $display("FAIL rf_issue: wr_req got %b want 1", wr_req); end
        cmd = REFRESH; rd_rdy = 1'b1; rd_data = 16'hDEAD;
        repeat (2) tick();
        cmd = NOP; rd_rdy = 1'b0;
        n_cmp++; if ({wr_req, rsp_valid, wr_addr, wr_data} !== {2'b10, e.addr, e.data}) begin n_err++; $display("FAIL rf_hold: got %b%b %h/%h want 10 %h/%h", wr_req, rsp_valid, wr_addr, wr_data, e.addr, e.data); end
        cmd = WRITE; tick(); cmd = NOP;
        n_cmp++; if (wr_req !== 1'b0) begin n_err++; $display("FAIL rf_done: got %b want 0", wr_req); end
    endtask

    task automatic test_read();
        exp_t e;
        bit   seen;
        push(1'b0, 22'h12345, 16'h0000);
        wait_req(10, seen);
        e = exp_q.pop_front();
        n_cmp++; if (!seen || {rd_req, wr_req, rd_addr} !== {2'b10, e.addr}) begin n_err++; $display("FAIL rd_issue: got %b%b %h want 10 %h", rd_req, wr_req, rd_addr, e.addr); end
        rd_rdy = 1'b1; rd_data = 16'hBEEF; tick(); rd_rdy = 1'b0; rd_data = 16'h0;
        n_cmp++; if ({rd_req, rsp_valid, rsp_data} !== {2'b01, 16'hBEEF}) begin n_err++; $display("FAIL rd_rsp: got %b%b %h want 01 beef", rd_req, rsp_valid, rsp_data); end
        tick();
        n_cmp++; if ({rsp_valid, idle} !== 2'b01) begin n_err++; $display("FAIL rd_pulse: rsp_valid/idle got %b want 01", {rsp_valid, idle}); end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        bit          seen;
        logic [15:0] rdv;
        push(1'b1, 22'h00001, 16'h1111);
        wait_req(10, seen);
        e = exp_q.pop_front();
        n_cmp++; if (!seen || {wr_req, wr_addr} !== {1'b1, e.addr}) begin n_err++; $display("FAIL b2b_blocker: got %b %h want 1 %h", wr_req, wr_addr, e.addr); end
        push(1'b0, 22'h00002, 16'h0000);
        push(1'b1, 22'h00003, 16'h3333);
        push(1'b0, 22'h00004, 16'h0000);
        push(1'b1, 22'h00005, 16'h5555);
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full: ready got %b want 0", req_ready); end
        cmd = WRITE; tick(); cmd = NOP;
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_still_full: ready got %b want 0", req_ready); end
        tick();
        n_cmp++; if ({req_ready, rd_req} !== 2'b11) begin n_err++; $display("FAIL b2b_pop: ready/rd_req got %b want 11", {req_ready, rd_req}); end
        push(1'b0, 22'h00006, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            wait_req(20, seen);
            e = exp_q.pop_front();
            n_cmp++;
            if (!seen || wr_req !== e.we || rd_req !== !e.we ||
                (e.we ? {wr_addr, wr_data} !== {e.addr, e.data} : rd_addr !== e.addr)) begin
                n_err++;
                $display("FAIL b2b_order[%0d]: got wr=%b rd=%b wa=%h wd=%h ra=%h want we=%b a=%h d=%h",
                         i, wr_req, rd_req, wr_addr, wr_data, rd_addr, e.we, e.addr, e.data);
            end
            if (e.we) begin
                cmd = WRITE; tick(); cmd = NOP;
            end else begin
                rdv = e.addr[15:0] ^ 16'hC3C3;
                rd_rdy = 1'b1; rd_data = rdv; tick(); rd_rdy = 1'b0;
                n_cmp++; if ({rsp_valid, rsp_data} !== {1'b1, rdv}) begin n_err++; $display("FAIL b2b_rsp[%0d]: got %b %h want 1 %h", i, rsp_valid, rsp_data, rdv); end
                tick();
            end
        end
        n_cmp++; if ({idle, exp_q.size() == 0} !== 2'b11) begin n_err++; $display("FAIL b2b_drain: idle got %b, %0d left", idle, exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        push(1'b0, 22'h2468A, 16'h0000);
        push(1'b1, 22'h13579, 16'h7777);
        wait_req(10, seen);
        n_cmp++; if (!seen || rd_req !== 1'b1) begin n_err++; $display("FAIL rm_issue: rd_req got %b want 1", rd_req); end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        exp_q.delete();
        n_cmp++; if ({rd_req, rsp_valid, idle, req_ready} !== 4'b0011) begin n_err++; $display("FAIL rm_state: rd/rsp/idle/ready got %b want 0011", {rd_req, rsp_valid, idle, req_ready}); end
        rd_rdy = 1'b1; cmd = WRITE;
        repeat (3) tick();
        rd_rdy = 1'b0; cmd = NOP;
        n_cmp++; if ({wr_req, rd_req, rsp_valid, idle} !== 4'b0001) begin n_err++; $display("FAIL rm_quiet: got %b want 0001", {wr_req, rd_req, rsp_valid, idle}); end
    endtask

`ifdef SDRAM_REQ_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit seen;
        int n = 0;
        exp_t e;
        push(1'b0, 22'h0F0F0, 16'h0000);
        wait_req(10, seen);
        void'(exp_q.pop_front());
        while (!err && n < 40) begin tick(); n++; end
        n_cmp++; if (n !== 16) begin n_err++; $display("FAIL to_latency: err after %0d cycles want 16", n); end
        n_cmp++; if ({err, rd_req, rsp_valid} !== 3'b100) begin n_err++; $display("FAIL to_state: err/rd/rsp got %b want 100", {err, rd_req, rsp_valid}); end
        push(1'b1, 22'h00F0F, 16'h4242);
        wait_req(10, seen);
        e = exp_q.pop_front();
        n_cmp++; if (!seen || {wr_req, wr_addr, err} !== {1'b1, e.addr, 1'b1}) begin n_err++; $display("FAIL to_next: got %b %h err=%b", wr_req, wr_addr, err); end
        cmd = WRITE; tick(); cmd = NOP;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_refresh_hold();
        test_read();
        test_back_to_back();
        test_reset_mid();
`ifdef SDRAM_REQ_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
